// File: rtl/rtm_pkg.sv
// Shared definitions for the register transfer link: word width, error word and
// the responder state encoding. The master-side manager imports the word width too.
package rtm_pkg;

    localparam int unsigned WORD_W = 32;

    localparam logic [WORD_W-1:0] ERR_WORD_DEFAULT = 32'hDEAD0BAD;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FWD_CMD,
        ST_SEND_RSN,
        ST_FWD_RES,
        ST_SEND_ERR
    } rtm_state_e;

endpackage

// File: rtl/register_transfer_responder_if.sv
// Handshake bundle of the responder: link receive/transmit streams toward the
// master and command/response streams toward the local IPbus packet handler.
interface register_transfer_responder_if;
    import rtm_pkg::*;

    logic [WORD_W-1:0] link_rx_data;
    logic              link_rx_valid;
    logic              link_rx_last;
    logic              link_rx_ready;

    logic [WORD_W-1:0] link_tx_data;
    logic              link_tx_valid;
    logic              link_tx_last;
    logic              link_tx_ready;

    logic [WORD_W-1:0] ipb_cmd_data;
    logic              ipb_cmd_valid;
    logic              ipb_cmd_last;
    logic              ipb_cmd_ready;

    logic [WORD_W-1:0] ipb_res_data;
    logic              ipb_res_valid;
    logic              ipb_res_last;
    logic              ipb_res_ready;

    // Responder side
    modport slave (
        input  link_rx_data, link_rx_valid, link_rx_last,
        output link_rx_ready,
        output link_tx_data, link_tx_valid, link_tx_last,
        input  link_tx_ready,
        output ipb_cmd_data, ipb_cmd_valid, ipb_cmd_last,
        input  ipb_cmd_ready,
        input  ipb_res_data, ipb_res_valid, ipb_res_last,
        output ipb_res_ready
    );

    // Link master plus local IPbus handler side
    modport master (
        output link_rx_data, link_rx_valid, link_rx_last,
        input  link_rx_ready,
        input  link_tx_data, link_tx_valid, link_tx_last,
        output link_tx_ready,
        input  ipb_cmd_data, ipb_cmd_valid, ipb_cmd_last,
        output ipb_cmd_ready,
        output ipb_res_data, ipb_res_valid, ipb_res_last,
        input  ipb_res_ready
    );

endinterface

// File: rtl/rtm_timeout_timer.sv
// Idle-cycle counter guarding the local response stream; clear restarts it,
// count-enable advances it and the expiry flag marks the final allowed idle cycle.
module rtm_timeout_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] cnt_q;
    logic [TW-1:0] cnt_d;

    assign expired_o = (cnt_q == TW'(TIMEOUT_CYCLES - 1));

    // Holds at expiry so a lingering enable can never wrap back to zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !expired_o) begin
            cnt_d = cnt_q + TW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/register_transfer_responder.sv
// Channel-side endpoint of the register transfer link: takes a CSN + command frame,
// forwards the commands locally, answers with RSN + local response, aborts on timeout.
module register_transfer_responder
    import rtm_pkg::*;
#(
    parameter int unsigned       TIMEOUT_CYCLES = 4096,
    parameter logic [WORD_W-1:0] ERR_WORD       = ERR_WORD_DEFAULT,
    parameter int unsigned       CNT_W          = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        enable,
    input  logic [WORD_W-1:0]           rsn,
    register_transfer_responder_if.slave bus,
    output logic [WORD_W-1:0]           csn_q,
    output logic                        busy,
    output logic [CNT_W-1:0]            frame_count,
    output logic [CNT_W-1:0]            error_count
);

    rtm_state_e        state_q, state_d;
    logic              enable_q;
    logic              live_q;
    logic [WORD_W-1:0] csn_d;
    logic [CNT_W-1:0]  frame_cnt_q;
    logic [CNT_W-1:0]  error_cnt_q;
    logic              frm_inc;
    logic              err_inc;
    logic              tmr_clr;
    logic              tmr_en;
    logic              tmr_exp;

    logic              rx_ready_c;
    logic [WORD_W-1:0] tx_data_c;
    logic              tx_valid_c;
    logic              tx_last_c;
    logic [WORD_W-1:0] cmd_data_c;
    logic              cmd_valid_c;
    logic              cmd_last_c;
    logic              res_ready_c;

    rtm_timeout_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (tmr_clr),
        .en_i     (tmr_en),
        .expired_o(tmr_exp)
    );

    always_comb begin
        state_d     = state_q;
        csn_d       = csn_q;
        frm_inc     = 1'b0;
        err_inc     = 1'b0;
        tmr_clr     = 1'b0;
        tmr_en      = 1'b0;
        rx_ready_c  = 1'b0;
        tx_data_c   = '0;
        tx_valid_c  = 1'b0;
        tx_last_c   = 1'b0;
        cmd_data_c  = '0;
        cmd_valid_c = 1'b0;
        cmd_last_c  = 1'b0;
        res_ready_c = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // live_q keeps every ready low for the first cycle after reset release.
                rx_ready_c  = enable_q && live_q;
                res_ready_c = live_q;
                if (bus.link_rx_valid && rx_ready_c) begin
                    if (bus.link_rx_last) begin
                        err_inc = 1'b1;
                    end else begin
                        csn_d   = bus.link_rx_data;
                        state_d = ST_FWD_CMD;
                    end
                end
            end

            ST_FWD_CMD: begin
                cmd_data_c  = bus.link_rx_data;
                cmd_valid_c = bus.link_rx_valid;
                cmd_last_c  = bus.link_rx_last;
                rx_ready_c  = bus.ipb_cmd_ready;
                if (bus.link_rx_valid && bus.ipb_cmd_ready && bus.link_rx_last) begin
                    state_d = ST_SEND_RSN;
                end
            end

            ST_SEND_RSN: begin
                tx_data_c  = rsn;
                tx_valid_c = 1'b1;
                if (bus.link_tx_ready) begin
                    tmr_clr = 1'b1;
                    state_d = ST_FWD_RES;
                end
            end

            ST_FWD_RES: begin
                tx_data_c   = bus.ipb_res_data;
                tx_valid_c  = bus.ipb_res_valid;
                tx_last_c   = bus.ipb_res_last;
                res_ready_c = bus.link_tx_ready;
                if (bus.ipb_res_valid && bus.link_tx_ready) begin
                    tmr_clr = 1'b1;
                    if (bus.ipb_res_last) begin
                        frm_inc = 1'b1;
                        state_d = ST_IDLE;
                    end
                end else if (!bus.ipb_res_valid) begin
                    // A word held back by link backpressure is not an idle cycle.
                    tmr_en = 1'b1;
                    if (tmr_exp) begin
                        state_d = ST_SEND_ERR;
                    end
                end
            end

            ST_SEND_ERR: begin
                tx_data_c  = ERR_WORD;
                tx_valid_c = 1'b1;
                tx_last_c  = 1'b1;
                if (bus.link_tx_ready) begin
                    err_inc = 1'b1;
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            enable_q    <= 1'b0;
            live_q      <= 1'b0;
            csn_q       <= '0;
            frame_cnt_q <= '0;
            error_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            enable_q <= enable;
            live_q   <= 1'b1;
            csn_q    <= csn_d;
            if (frm_inc && (frame_cnt_q != '1)) begin
                frame_cnt_q <= frame_cnt_q + CNT_W'(1);
            end
            if (err_inc && (error_cnt_q != '1)) begin
                error_cnt_q <= error_cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.link_rx_ready = rx_ready_c;
    assign bus.link_tx_data  = tx_data_c;
    assign bus.link_tx_valid = tx_valid_c;
    assign bus.link_tx_last  = tx_last_c;
    assign bus.ipb_cmd_data  = cmd_data_c;
    assign bus.ipb_cmd_valid = cmd_valid_c;
    assign bus.ipb_cmd_last  = cmd_last_c;
    assign bus.ipb_res_ready = res_ready_c;

    assign busy        = (state_q != ST_IDLE);
    assign frame_count = frame_cnt_q;
    assign error_count = error_cnt_q;

endmodule

// File: doc/register_transfer_responder.md
Name: register_transfer_responder

Overview:
- Channel-side endpoint of the register transfer link; the counterpart of the master-side manager that sends a CSN word plus IPbus command words and expects an RSN word plus response words.
- Accepts one link frame: a CSN header word, then command words ending in last.
- Forwards the command words to the local IPbus packet handler, returns RSN, then streams the local response back over the link.
- Guards against a hung local responder with a timeout that terminates the frame with an error word.

Parameters:
TIMEOUT_CYCLES, 4096, idle cycles allowed between response beats (and before the first) before abort
ERR_WORD, 32'hDEAD0BAD, word sent with last=1 on timeout
CNT_W, 16, width of status counters (saturating)

Ports:
clk  in  1  single clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  allow new frames to start (sampled into enable_q)
rsn  in  32  response serial number sent as first response word
link_rx_data  in  32  frame words from master
link_rx_valid  in  1  link_rx_data valid
link_rx_last  in  1  last word of frame
link_rx_ready  out  1  responder accepts link word
link_tx_data  out  32  response frame words to master
link_tx_valid  out  1  link_tx_data valid
link_tx_last  out  1  last response word
link_tx_ready  in  1  master/FIFO accepts word
ipb_cmd_data  out  32  command word to local IPbus
ipb_cmd_valid  out  1  command valid
ipb_cmd_last  out  1  last command word
ipb_cmd_ready  in  1  local IPbus accepts
ipb_res_data  in  32  local response word
ipb_res_valid  in  1  response valid
ipb_res_last  in  1  last response word
ipb_res_ready  out  1  responder accepts response
csn_q  out  32  CSN of most recent frame
busy  out  1  state != IDLE
frame_count  out  CNT_W  frames completed normally
error_count  out  CNT_W  runt frames + timeouts

Behaviour:
- Beat = valid && ready in same cycle; valid/data/last held by the sender until the beat.
- Reset (async): state IDLE, enable_q=0, csn_q=0, counters=0, timer=0. All handshake outputs are 0 while rst_n is low and in the first cycle after release.
- enable_q <= enable each clk.
- Mid-frame reset aborts the frame silently; the master side is reset by the same system reset.
- States: IDLE, FWD_CMD, SEND_RSN, FWD_RES, SEND_ERR.
- IDLE:
  - link_rx_ready = enable_q; ipb_res_ready=1 (stray late responses discarded).
  - CSN beat without last: csn_q <= data, go to FWD_CMD.
  - CSN beat with last: runt frame; error_count++, stay IDLE.
- FWD_CMD: zero-latency pass-through.
  - ipb_cmd_{data,valid,last} = link_rx_{data,valid,last}; link_rx_ready = ipb_cmd_ready.
  - Beat with last: go to SEND_RSN.
- SEND_RSN: link_tx_data=rsn, valid=1, last=0.
  - On link_tx_ready: go to FWD_RES, timer <= 0.
- FWD_RES: pass-through.
  - link_tx_{data,valid,last} = ipb_res_{data,valid,last}; ipb_res_ready = link_tx_ready.
  - On each beat: timer <= 0. Beat with last: frame_count++, go to IDLE.
  - With no beat: timer++. When timer == TIMEOUT_CYCLES-1 and no beat this cycle: go to SEND_ERR.
  - Timer stalls while ipb_res_valid=1 and link_tx_ready=0, so backpressure is never a timeout.
- SEND_ERR: link_tx_data=ERR_WORD, valid=1, last=1; ipb_res_ready=0.
  - On ready: error_count++, go to IDLE.
- Counters saturate at all-ones.
- enable going low mid-frame does not abort; it only blocks the next CSN.
- Outside the listed states, ready/valid outputs are 0 and data outputs are 0.

Decomposition:
- Shared package rtm_pkg: state enum, ERR_WORD default, frame word width constant (32). The master-side manager reuses the word width.
- One natural sub-module: rtm_timeout_timer, a loadable counter with clear, count-enable and expiry flag, parameterised by TIMEOUT_CYCLES.

Test Plan:
- Nominal frame: CSN=0x00000005, cmd {0x20000F00, 0x00000001 last}, local res {0x20000F10, 0xCAFEF00D last}, rsn=0x000000A5.
  -> ipb_cmd sees 2 words with last on 2nd.
  -> link_tx emits 0xA5, 0x20000F10, 0xCAFEF00D(last).
  -> csn_q=5, frame_count=1.
- Backpressure: ipb_cmd_ready toggled 1/0 each cycle; link_tx_ready low 10000 cycles during FWD_RES with ipb_res_valid=1.
  -> no word lost or duplicated; no timeout; error_count=0.
- Timeout: command completes, local never responds, TIMEOUT_CYCLES=16.
  -> link_tx emits rsn, then ERR_WORD(last) 16 cycles after the RSN beat; error_count=1.
  -> late res beat afterwards is absorbed in IDLE; no link_tx output.
- Runt frame: single word 0x00000007 with last=1.
  -> no ipb_cmd activity, no link_tx output, error_count=1, csn_q unchanged.
- Enable/reset: enable=0 with CSN valid -> link_rx_ready=0, frame not accepted.
  -> rst_n pulsed low during FWD_RES -> all outputs 0 immediately, busy=0, counters 0, next frame completes normally.
